// File: rtl/avalon_mem_master_if.sv
// avalon_mem_master_if: Avalon-MM bus between the CPU-side master and the memory.
interface avalon_mem_master_if;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic        waitrequest;
  modport master(output address, read, write, byteenable, writedata, input readdata, waitrequest);
  modport slave(input address, read, write, byteenable, writedata, output readdata, waitrequest);
endinterface

// File: rtl/avalon_mem_master.sv
// avalon_mem_master: single-outstanding CPU load/store to Avalon-MM word transfers, big-endian lanes.
module avalon_mem_master (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req,
  input  logic                        we,
  input  logic [1:0]                  size,
  input  logic                        sign_ext,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [31:0]                 cpu_rdata,
  avalon_mem_master_if.master         bus
);
  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;
  state_t      state;
  logic [31:0] address, writedata;
  logic [3:0]  byteenable;
  logic        read, write;
  logic [1:0]  off_q, size_q;
  logic        sext_q;
  logic        legal;
  logic [3:0]  be_c;
  logic [4:0]  wsh, rsh;
  logic [31:0] wd_c, rd_sh, rd_ext;
  assign bus.address    = address;
  assign bus.writedata  = writedata;
  assign bus.byteenable = byteenable;
  assign bus.read       = read;
  assign bus.write      = write;
  assign legal = size == 2'b00 || (size == 2'b01 && !cpu_addr[0]) || (size == 2'b10 && cpu_addr[1:0] == 2'b00);
  // lane k sits at bits [31-8k:24-8k], so byte/half offsets shift by 8*(3-k) / 8*(2-k)
  always_comb begin
    be_c   = size == 2'b00 ? 4'b0001 << cpu_addr[1:0] : size == 2'b01 ? (cpu_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wsh    = size == 2'b00 ? {~cpu_addr[1:0], 3'b000} : size == 2'b01 ? {~cpu_addr[1], 4'b0000} : 5'd0;
    wd_c   = (size == 2'b00 ? {24'b0, cpu_wdata[7:0]} : size == 2'b01 ? {16'b0, cpu_wdata[15:0]} : cpu_wdata) << wsh;
    rsh    = size_q == 2'b00 ? {~off_q, 3'b000} : {~off_q[1], 4'b0000};
    rd_sh  = bus.readdata >> rsh;
    rd_ext = size_q == 2'b10 ? bus.readdata :
             size_q == 2'b01 ? {{16{sext_q & rd_sh[15]}}, rd_sh[15:0]} :
                               {{24{sext_q & rd_sh[7]}}, rd_sh[7:0]};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      cpu_rdata  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          busy <= 1'b1;
          if (legal) begin
            state      <= REQ;
            read       <= ~we;
            write      <= we;
            address    <= {cpu_addr[31:2], 2'b00};
            byteenable <= be_c;
            writedata  <= wd_c;
            off_q      <= cpu_addr[1:0];
            size_q     <= size;
            sext_q     <= sign_ext;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        REQ: if (!bus.waitrequest) begin
          read  <= 1'b0;
          write <= 1'b0;
          done  <= write;
          state <= write ? DONE : RDATA;
        end
        RDATA: begin
          cpu_rdata <= rd_ext;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_avalon_mem_master.sv
// tb_avalon_mem_master: directed plus random loads/stores against a byte-addressed big-endian memory model.
module tb_avalon_mem_master;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        busy, done, err;
  logic [31:0] cpu_rdata;
  avalon_mem_master_if bus();
  avalon_mem_master dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .busy(busy), .done(done), .err(err),
    .cpu_rdata(cpu_rdata), .bus(bus.master)
  );
  logic [7:0]  ref_b [64];
  logic [7:0]  bus_b [64];
  logic [31:0] exp_rd = '0;
  int wait_cfg = 0, wcnt = 0, accepts = 0;
  int errors = 0, checks = 0;
  bit load_mem = 1'b0;
  assign bus.waitrequest = (wcnt != 0);
  always @(posedge clk)
    if (load_mem) begin
      for (int i = 0; i < 64; i++) bus_b[i] <= ref_b[i];
    end else if (bus.read || bus.write) begin
      if (wcnt != 0) wcnt <= wcnt - 1;
      else begin
        accepts <= accepts + 1;
        if (bus.write)
          for (int k = 0; k < 4; k++)
            if (bus.byteenable[k]) bus_b[{bus.address[5:2], k[1:0]}] <= bus.writedata[31-8*k -: 8];
        if (bus.read)
          bus.readdata <= {bus_b[{bus.address[5:2], 2'd0}], bus_b[{bus.address[5:2], 2'd1}],
                           bus_b[{bus.address[5:2], 2'd2}], bus_b[{bus.address[5:2], 2'd3}]};
      end
    end else wcnt <= wait_cfg;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int wt);
    int nb, n, acc0;
    bit legal, seen, both, allbusy;
    logic [3:0]  ebe, gbe;
    logic [31:0] ewd, gwd, gad, v;
    logic [5:0]  p;
    logic [7:0]  b;
    nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    legal = (sz != 2'b11) && (int'(a[1:0]) % nb == 0);
    ebe = '0; ewd = '0; v = '0;
    if (legal)
      for (int i = 0; i < nb; i++) begin
        p = a[5:0] + i[5:0];
        ebe[p[1:0]] = 1'b1;
        if (w) begin
          b = wd[8*(nb-1-i) +: 8];
          ewd[31-8*p[1:0] -: 8] = b;
          ref_b[p] = b;
        end else v = {v[23:0], ref_b[p]};
      end
    if (legal && !w)
      exp_rd = (nb == 4 || !sx) ? v : nb == 2 ? {{16{v[15]}}, v[15:0]} : {{24{v[7]}}, v[7:0]};
    wait_cfg = wt; we = w; size = sz; sign_ext = sx; cpu_addr = a; cpu_wdata = wd; req = 1'b1;
    acc0 = accepts;
    n = 0; seen = 0; both = 0; allbusy = 1; gbe = '0; gwd = '0; gad = '0;
    do begin
      @(posedge clk); #1;
      req = 1'b0;
      n++;
      allbusy &= busy;
      if (bus.read || bus.write) begin
        seen = 1;
        both |= bus.read && bus.write;
        gbe = bus.byteenable; gwd = bus.writedata; gad = bus.address;
      end
    end while (!done && n < 40);
    chk("done", done, 1);
    chk("latency", n, legal ? (w ? 2 : 3) + wt : 1);
    chk("err", err, !legal);
    chk("busy_held", allbusy, 1);
    chk("accepts", accepts - acc0, legal);
    chk("bus_activity", seen, legal);
    chk("rd_wr_overlap", both, 0);
    if (legal) begin
      chk("byteenable", gbe, ebe);
      chk("address", gad, {a[31:2], 2'b00});
    end
    if (legal && w) chk("writedata", gwd, ewd);
    chk("cpu_rdata", cpu_rdata, exp_rd);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("idle", busy, 0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
    ref_b[4] = 8'h88; ref_b[5] = 8'h99; ref_b[6] = 8'hAA; ref_b[7] = 8'hBB;
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 load_mem = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_read", bus.read, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", cpu_rdata, 0);
    @(negedge clk) reset_n = 1'b1;
    access(0, 2'b10, 0, 32'hBFC00004, 0, 3);
    chk("lw_lit", cpu_rdata, 32'h8899AABB);
    access(0, 2'b00, 1, 32'hBFC00005, 0, 0);
    chk("lb_lit", cpu_rdata, 32'hFFFFFF99);
    access(0, 2'b00, 0, 32'hBFC00005, 0, 1);
    chk("lbu_lit", cpu_rdata, 32'h00000099);
    access(0, 2'b01, 1, 32'hBFC00006, 0, 0);
    chk("lh_lit", cpu_rdata, 32'hFFFFAABB);
    access(0, 2'b01, 0, 32'hBFC00006, 0, 2);
    chk("lhu_lit", cpu_rdata, 32'h0000AABB);
    access(1, 2'b00, 0, 32'hBFC00007, 32'h1234565A, 0);
    access(0, 2'b10, 1, 32'hBFC00004, 0, 0);
    chk("lw_after_sb", cpu_rdata, 32'h8899AA5A);
    access(0, 2'b10, 0, 32'hBFC00002, 0, 0);
    access(1, 2'b01, 0, 32'hBFC00001, 32'hFFFF, 0);
    access(0, 2'b11, 0, 32'hBFC00000, 0, 0);
    chk("illegal_keeps_rdata", cpu_rdata, 32'h8899AA5A);
    wait_cfg = 20;
    we = 1'b0; size = 2'b10; cpu_addr = 32'hBFC00004; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_read", bus.read, 1);
    #2 reset_n = 1'b0;
    #1;
    exp_rd = '0;
    chk("arst_read", bus.read, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", bus.address, 0);
    chk("arst_be", bus.byteenable, 0);
    chk("arst_rdata", cpu_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", done, 0);
    end
    @(negedge clk) reset_n = 1'b1;
    access(0, 2'b10, 0, 32'hBFC00004, 0, 0);
    for (int i = 0; i < 40; i++)
      access(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), 1'($urandom),
             32'hBFC00000 | 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
